// File: rtl/ahb_bridge_arbiter_if.sv
// Bundle of requester-side and bridge-side signals around ahb_bridge_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, which is the requesters plus the bridge.
interface ahb_bridge_arbiter_if #(
  parameter int NM = 3
);
  logic [NM-1:0]      hbusreq;
  logic [NM-1:0]      hlock;
  logic [2*NM-1:0]    m_htrans;
  logic [32*NM-1:0]   m_haddr;
  logic [NM-1:0]      m_hwrite;
  logic [32*NM-1:0]   m_hwdata;
  logic [NM-1:0]      hgrant;
  logic [1:0]         hmaster;
  logic               m_hready;
  logic [31:0]        m_hrdata;
  logic [1:0]         htrans;
  logic [31:0]        haddr;
  logic               hwrite;
  logic [31:0]        hwdata;
  logic               hready_in;
  logic               hr_readyout;
  logic [31:0]        hr_data;

  modport slave (
    input  hbusreq, hlock, m_htrans, m_haddr, m_hwrite, m_hwdata, hr_readyout, hr_data,
    output hgrant, hmaster, m_hready, m_hrdata, htrans, haddr, hwrite, hwdata, hready_in
  );

  modport master (
    output hbusreq, hlock, m_htrans, m_haddr, m_hwrite, m_hwdata, hr_readyout, hr_data,
    input  hgrant, hmaster, m_hready, m_hrdata, htrans, haddr, hwrite, hwdata, hready_in
  );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter that shares the AHB slave port of the AHB-to-APB bridge
// between NM requesters. It owns the grant, the address-phase and data-phase
// muxing, and the per-tenure beat limit.
// Optional feature: define ARB_HLOCK_EN so that hlock suppresses preemption.
// NM must match the NM parameter of the connected interface instance.
module ahb_bridge_arbiter #(
  parameter int NM        = 3,
  parameter int MAX_BEATS = 8
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  ahb_bridge_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_reg;
  logic [NM-1:0]   hgrant_reg;
  logic [1:0]      hmaster_reg;
  logic [1:0]      data_owner_reg;
  logic [1:0]      start_reg;      // first index examined by the next search
  logic [CW-1:0]   count_reg;

  logic [1:0]      own_htrans;
  logic [31:0]     own_haddr;
  logic            own_hwrite;
  logic            own_req;
  logic            own_lock;
  logic [NM-1:0]   own_mask;
  logic            others_req;
  logic            beat;
  logic            limit_hit;
  logic            arb;
  logic            found;
  logic [1:0]      winner;

  assign own_htrans = bus.m_htrans[2*int'(hmaster_reg) +: 2];
  assign own_haddr  = bus.m_haddr[32*int'(hmaster_reg) +: 32];
  assign own_hwrite = bus.m_hwrite[hmaster_reg];
  assign own_req    = bus.hbusreq[hmaster_reg];
  assign own_mask   = {{(NM-1){1'b0}}, 1'b1} << hmaster_reg;
  assign others_req = (bus.hbusreq & ~own_mask) != '0;

`ifdef ARB_HLOCK_EN
  // A locked owner that still requests cannot be displaced by idle cycles or by the beat limit.
  assign own_lock = bus.hlock[hmaster_reg] & own_req;
`else
  logic unused_hlock;
  assign unused_hlock = ^bus.hlock;
  assign own_lock     = 1'b0;
`endif

  // A beat is an accepted NONSEQ/SEQ address phase of the current owner.
  assign beat = (state_reg == OWN) && own_htrans[1];

  // The limit includes the beat that is accepted in this cycle. This way the
  // grant moves right after the MAX_BEATS-th beat, and the next beat never
  // reaches the bridge.
  assign limit_hit = (count_reg == CW'(MAX_BEATS)) ||
                     (beat && (count_reg == CW'(MAX_BEATS - 1)));

  assign arb = bus.hr_readyout &&
               ((state_reg == IDLE) || !own_req ||
                ((own_htrans == 2'b00) && !own_lock) ||
                (limit_hit && others_req && !own_lock));

  // Circular search for the first request, starting at start_reg.
  always_comb begin
    found  = 1'b0;
    winner = start_reg;
    for (int k = 0; k < NM; k++) begin
      if (!found && bus.hbusreq[(int'(start_reg) + k) % NM]) begin
        found  = 1'b1;
        winner = 2'((int'(start_reg) + k) % NM);
      end
    end
  end

  // Grant FSM, data-phase owner and beat counter. Everything holds during wait states.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg      <= IDLE;
      hgrant_reg     <= '0;
      hmaster_reg    <= 2'd0;
      data_owner_reg <= 2'd0;
      start_reg      <= 2'd0;
      count_reg      <= '0;
    end else if (bus.hr_readyout) begin
      data_owner_reg <= hmaster_reg;
      if (arb) begin
        count_reg <= '0;
        if (found) begin
          state_reg   <= OWN;
          hgrant_reg  <= {{(NM-1){1'b0}}, 1'b1} << winner;
          hmaster_reg <= winner;
          start_reg   <= (int'(winner) == NM - 1) ? 2'd0 : winner + 2'd1;
        end else begin
          state_reg  <= IDLE;
          hgrant_reg <= '0;
        end
      end else if (beat && (count_reg != CW'(MAX_BEATS))) begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign bus.hgrant    = hgrant_reg;
  assign bus.hmaster   = hmaster_reg;
  assign bus.m_hready  = bus.hr_readyout;
  assign bus.m_hrdata  = bus.hr_data;
  assign bus.hready_in = bus.hr_readyout;
  assign bus.htrans    = (state_reg == OWN) ? own_htrans : 2'b00;
  assign bus.haddr     = (state_reg == OWN) ? own_haddr  : 32'd0;
  assign bus.hwrite    = (state_reg == OWN) ? own_hwrite : 1'b0;
  assign bus.hwdata    = bus.m_hwdata[32*int'(data_owner_reg) +: 32];
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter. It uses directed stimulus and a transfer scoreboard.
// The stimulus pushes each transfer that the bridge must accept. A monitor
// matches each accepted address phase, and then its data phase, against the queue.
module tb_ahb_bridge_arbiter;
  localparam int NM = 3;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  logic  hclk;
  logic  hresetn;
  int    tests;
  int    fails;
  xfer_t exp_q[$];

  ahb_bridge_arbiter_if #(.NM(NM)) bus ();

  ahb_bridge_arbiter #(.NM(NM), .MAX_BEATS(8)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic smp();
    @(negedge hclk);
  endtask

  task automatic set_m(input int m, input logic [1:0] t, input logic [31:0] a, input logic w);
    bus.m_htrans[2*m +: 2] = t;
    bus.m_haddr[32*m +: 32] = a;
    bus.m_hwrite[m]         = w;
  endtask

  task automatic set_d(input int m, input logic [31:0] d);
    bus.m_hwdata[32*m +: 32] = d;
  endtask

  task automatic push(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.m = m; x.addr = a; x.wr = w; x.data = d;
    exp_q.push_back(x);
  endtask

  // Monitor: an address phase is captured on a ready cycle, and completed on the next ready cycle.
  initial begin
    xfer_t pend;
    xfer_t e;
    logic  pend_v;
    pend_v = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        pend_v = 1'b0;
      end else if (bus.hr_readyout) begin
        if (pend_v) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got m%0d addr %0h, want no transfer", pend.m, pend.addr);
          end else begin
            e = exp_q.pop_front();
            if (pend.m != e.m || pend.addr !== e.addr || pend.wr !== e.wr ||
                (e.wr && bus.hwdata !== e.data)) begin
              fails++;
              $display("FAIL sb_xfer: got m%0d addr %0h wr %0b data %0h, want m%0d addr %0h wr %0b data %0h",
                       pend.m, pend.addr, pend.wr, bus.hwdata, e.m, e.addr, e.wr, e.data);
            end else begin
              $display("[TB] xfer m%0d addr %08h wr %0b data %08h ok", e.m, e.addr, e.wr,
                       e.wr ? bus.hwdata : 32'h0);
            end
          end
        end
        pend_v = bus.htrans[1];
        if (bus.htrans[1]) begin
          pend.m    = int'(bus.hmaster);
          pend.addr = bus.haddr;
          pend.wr   = bus.hwrite;
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    hresetn         = 1'b0;
    bus.hbusreq     = '0;
    bus.hlock       = '0;
    bus.m_htrans    = '0;
    bus.m_haddr     = '0;
    bus.m_hwrite    = '0;
    bus.m_hwdata    = '0;
    bus.hr_readyout = 1'b1;
    bus.hr_data     = 32'h87654321;
    set_d(0, 32'h11110000);
    set_d(1, 32'h22220000);
    set_m(1, T_NSEQ, 32'h0000_0F00, 1'b1);

    // Reset values
    smp();
    chk("rst_hgrant", 32'(bus.hgrant), 32'h0);
    chk("rst_hmaster", 32'(bus.hmaster), 32'h0);
    chk("rst_htrans", 32'(bus.htrans), 32'h0);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwrite", 32'(bus.hwrite), 32'h0);
    chk("rst_hwdata", bus.hwdata, 32'h11110000);
    chk("rst_hrdata", bus.m_hrdata, 32'h87654321);
    chk("rst_hready", 32'({bus.m_hready, bus.hready_in}), 32'h3);
    cyc();
    hresetn = 1'b1;
    set_m(1, T_IDLE, 32'h0, 1'b0);
    smp();

    // Simultaneous requests: grant order is 0, 1, 2. Each requester does one single transfer.
    cyc();
    bus.hbusreq = 3'b111;
    smp();
    chk("s2_pre_grant", 32'(bus.hgrant), 32'h0);
    for (int m = 0; m < NM; m++) begin
      cyc();
      set_m(m, T_NSEQ, 32'h100 + 32'(16*m), (m != 1));
      push(m, 32'h100 + 32'(16*m), (m != 1), 32'hD000_0000 + 32'(m));
      smp();
      chk($sformatf("s2_grant%0d", m), 32'(bus.hgrant), 32'(1 << m));
      chk($sformatf("s2_hmaster%0d", m), 32'(bus.hmaster), 32'(m));
      cyc();
      set_m(m, T_IDLE, 32'h0, 1'b0);
      set_d(m, 32'hD000_0000 + 32'(m));
      bus.hbusreq[m] = 1'b0;
      smp();
      chk($sformatf("s2_hold%0d", m), 32'(bus.hgrant), 32'(1 << m));
    end
    cyc();
    smp();
    chk("s2_idle_grant", 32'(bus.hgrant), 32'h0);
    chk("s2_idle_htrans", 32'(bus.htrans), 32'h0);

    // Data-phase steering across a handover
    cyc();
    bus.hbusreq = 3'b011;
    smp();
    cyc();
    set_m(0, T_NSEQ, 32'h10, 1'b1);
    set_d(0, 32'hAAAA0000);
    set_d(1, 32'h00005555);
    bus.hbusreq[0] = 1'b0;
    push(0, 32'h10, 1'b1, 32'hAAAA0000);
    smp();
    chk("s3_grant0", 32'(bus.hgrant), 32'h1);
    cyc();
    set_m(0, T_IDLE, 32'h0, 1'b0);
    set_m(1, T_NSEQ, 32'h20, 1'b1);
    bus.hbusreq[1] = 1'b0;
    push(1, 32'h20, 1'b1, 32'h00005555);
    smp();
    chk("s3_grant1", 32'(bus.hgrant), 32'h2);
    chk("s3_haddr1", bus.haddr, 32'h20);
    chk("s3_hwdata0", bus.hwdata, 32'hAAAA0000);
    cyc();
    set_m(1, T_IDLE, 32'h0, 1'b0);
    smp();
    chk("s3_hwdata1", bus.hwdata, 32'h00005555);
    chk("s3_idle_haddr", bus.haddr, 32'h0);
    chk("s3_idle_grant", 32'(bus.hgrant), 32'h0);

    // Wait states during an owner release
    cyc();
    bus.hbusreq = 3'b001;
    smp();
    cyc();
    set_m(0, T_NSEQ, 32'h40, 1'b1);
    bus.hbusreq = 3'b010;
    bus.hr_readyout = 1'b0;
    push(0, 32'h40, 1'b1, 32'h1234);
    smp();
    chk("s4_grant_w0", 32'(bus.hgrant), 32'h1);
    chk("s4_m_hready", 32'({bus.m_hready, bus.hready_in}), 32'h0);
    for (int w = 1; w < 3; w++) begin
      cyc();
      smp();
      chk($sformatf("s4_grant_w%0d", w), 32'(bus.hgrant), 32'h1);
    end
    cyc();
    bus.hr_readyout = 1'b1;
    bus.hr_data = 32'h0BADF00D;
    smp();
    chk("s4_grant_ready", 32'(bus.hgrant), 32'h1);
    chk("s4_hrdata", bus.m_hrdata, 32'h0BADF00D);
    cyc();
    set_m(0, T_IDLE, 32'h0, 1'b0);
    set_d(0, 32'h1234);
    bus.hbusreq = 3'b000;
    smp();
    chk("s4_grant_after", 32'(bus.hgrant), 32'h2);
    cyc();
    smp();

`ifdef ARB_HLOCK_EN
    // Lock: master 0 keeps the bus for all 16 beats.
    cyc();
    bus.hbusreq = 3'b011;
    bus.hlock = 3'b001;
    smp();
    for (int b = 0; b < 16; b++) begin
      cyc();
      set_m(0, (b == 0) ? T_NSEQ : T_SEQ, 32'h400 + 32'(4*b), 1'b1);
      if (b > 0) set_d(0, 32'h400 + 32'(4*(b-1)));
      if (b == 15) bus.hbusreq = 3'b010;
      push(0, 32'h400 + 32'(4*b), 1'b1, 32'h400 + 32'(4*b));
      smp();
      chk($sformatf("lk_hold%0d", b), 32'(bus.hgrant), 32'h1);
    end
    cyc();
    set_m(0, T_IDLE, 32'h0, 1'b0);
    set_d(0, 32'h43C);
    bus.hlock = 3'b000;
    set_m(1, T_NSEQ, 32'h500, 1'b1);
    set_d(1, 32'h500);
    bus.hbusreq = 3'b000;
    push(1, 32'h500, 1'b1, 32'h500);
    smp();
    chk("lk_grant1", 32'(bus.hgrant), 32'h2);
    cyc();
    set_m(1, T_IDLE, 32'h0, 1'b0);
    smp();
`endif

    // Preemption after 8 beats of a 16-beat INCR
    cyc();
    bus.hbusreq = 3'b011;
    smp();
    for (int b = 0; b < 8; b++) begin
      cyc();
      set_m(0, (b == 0) ? T_NSEQ : T_SEQ, 32'h200 + 32'(4*b), 1'b1);
      if (b > 0) set_d(0, 32'h200 + 32'(4*(b-1)));
      push(0, 32'h200 + 32'(4*b), 1'b1, 32'h200 + 32'(4*b));
      smp();
      chk($sformatf("s5_hold%0d", b), 32'(bus.hgrant), 32'h1);
    end
    cyc();
    set_m(0, T_SEQ, 32'h220, 1'b1);
    set_d(0, 32'h21C);
    set_m(1, T_NSEQ, 32'h300, 1'b1);
    set_d(1, 32'h300);
    bus.hbusreq = 3'b001;
    push(1, 32'h300, 1'b1, 32'h300);
    smp();
    chk("s5_preempt_grant", 32'(bus.hgrant), 32'h2);
    chk("s5_preempt_hmaster", 32'(bus.hmaster), 32'h1);
    chk("s5_preempt_haddr", bus.haddr, 32'h300);
    cyc();
    set_m(1, T_IDLE, 32'h0, 1'b0);
    set_m(0, T_NSEQ, 32'h220, 1'b1);
    set_d(0, 32'h220);
    bus.hbusreq = 3'b000;
    push(0, 32'h220, 1'b1, 32'h220);
    smp();
    chk("s5_regrant", 32'(bus.hgrant), 32'h1);
    cyc();
    set_m(0, T_IDLE, 32'h0, 1'b0);
    smp();
    chk("s5_idle", 32'(bus.hgrant), 32'h0);

    // Reset mid-burst while master 1 owns the bus
    cyc();
    bus.hbusreq = 3'b010;
    smp();
    cyc();
    set_m(1, T_NSEQ, 32'h600, 1'b1);
    push(1, 32'h600, 1'b1, 32'h600);
    smp();
    chk("s6_grant1", 32'(bus.hgrant), 32'h2);
    cyc();
    set_m(1, T_SEQ, 32'h604, 1'b1);
    set_d(1, 32'h600);
    smp();
    cyc();
    set_m(1, T_SEQ, 32'h608, 1'b1);
    set_d(1, 32'h604);
    set_d(0, 32'hCAFE0000);
    hresetn = 1'b0;
    #1;
    chk("s6_rst_hgrant", 32'(bus.hgrant), 32'h0);
    chk("s6_rst_hmaster", 32'(bus.hmaster), 32'h0);
    chk("s6_rst_htrans", 32'(bus.htrans), 32'h0);
    chk("s6_rst_haddr", bus.haddr, 32'h0);
    chk("s6_rst_hwrite", 32'(bus.hwrite), 32'h0);
    chk("s6_rst_hwdata", bus.hwdata, 32'hCAFE0000);
    smp();
    cyc();
    hresetn = 1'b1;
    set_m(1, T_IDLE, 32'h0, 1'b0);
    bus.hbusreq = 3'b001;
    smp();
    chk("s6_post_pre", 32'(bus.hgrant), 32'h0);
    cyc();
    smp();
    chk("s6_post_grant", 32'(bus.hgrant), 32'h1);
    chk("s6_post_hmaster", 32'(bus.hmaster), 32'h0);
    cyc();
    bus.hbusreq = 3'b000;
    smp();
    cyc();
    smp();

    chk("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
